// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin memory arbiter with ack-timeout watchdog
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_NUM   = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  m0_rd_en,
    input  logic                  m0_wr_en,
    input  logic [BYTE_NUM-1:0]   m0_byte_en,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_rd_en,
    input  logic                  m1_wr_en,
    input  logic [BYTE_NUM-1:0]   m1_byte_en,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [BYTE_NUM-1:0]   mem_byte_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ack
);

    // Counter only ever reaches TIMEOUT-1 before the grant is released.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic req0, req1, granted, sel1, req_g, complete, timeout_hit;

    // Decode the grant and the two ways a grant can finish with an ack.
    always_comb begin
        req0        = m0_rd_en | m0_wr_en;
        req1        = m1_rd_en | m1_wr_en;
        granted     = (state_q == GRANT0) || (state_q == GRANT1);
        sel1        = (state_q == GRANT1);
        req_g       = sel1 ? req1 : req0;
        complete    = granted && req_g && mem_ack;
        timeout_hit = granted && req_g && !mem_ack && (cnt_q == CNT_LAST);
    end

    // Slave port mux: granted master drives the bus, write beats read, watchdog kills enables.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_byte_en = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (granted) begin
            mem_byte_en = sel1 ? m1_byte_en : m0_byte_en;
            mem_addr    = sel1 ? m1_addr    : m0_addr;
            mem_wr_data = sel1 ? m1_wr_data : m0_wr_data;
            mem_wr_en   = sel1 ? m1_wr_en   : m0_wr_en;
            mem_rd_en   = (sel1 ? m1_rd_en : m0_rd_en) & ~mem_wr_en;
            if (timeout_hit) begin
                mem_rd_en = 1'b0;
                mem_wr_en = 1'b0;
            end
        end
    end

    // Completion signalling back to the masters; only the owner ever sees ack or data.
    always_comb begin
        m0_ack     = (state_q == GRANT0) && (complete || timeout_hit);
        m1_ack     = (state_q == GRANT1) && (complete || timeout_hit);
        m0_err     = (state_q == GRANT0) && timeout_hit;
        m1_err     = (state_q == GRANT1) && timeout_hit;
        m0_rd_data = ((state_q == GRANT0) && complete) ? mem_rd_data : '0;
        m1_rd_data = ((state_q == GRANT1) && complete) ? mem_rd_data : '0;
    end

    // Round-robin arbitration in IDLE; grant held until ack, abort or timeout.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (!req_g || mem_ack || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, round-robin pointer and watchdog counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
